uart_sample_framer: RTL and testbench
=====================================

# uart_sample_framer

Packs stereo audio samples from the WM8731 capture path into fixed 6-byte frames and feeds them byte-by-byte into the UART transmitter's load/ready handshake. It sits directly upstream of the UART TX side. It buffers samples in a small FIFO so that codec-rate bursts survive UART back-pressure, and it reports overflow and drop statistics.

## Interface

Parameters:
- FIFO_ADDR_WIDTH, 3 — FIFO depth = 2^FIFO_ADDR_WIDTH frames (default 8).
- SYNC_BYTE, 8'hA5 — first byte of every frame.

Ports:
- clockIN  in  1  — single system clock; all logic is on its rising edge.
- nResetIN  in  1  — asynchronous, active-low reset.
- sampleLeftIN  in  16  — left sample; qualified by sampleValidIN.
- sampleRightIN  in  16  — right sample; qualified by sampleValidIN.
- sampleValidIN  in  1  — one-cycle strobe; pushes the L/R pair into the FIFO.
- txDataOUT  out  8  — byte presented to the UART TX.
- txLoadOUT  out  1  — load request to the UART TX.
- txReadyIN  in  1  — UART TX ready; low = byte accepted/transmitting, high = ready for the next byte. Synchronous to clockIN.
- fifoCountOUT  out  FIFO_ADDR_WIDTH+1  — frames currently buffered.
- overflowOUT  out  1  — sticky; set on the first dropped sample pair.
- dropCountOUT  out  8  — dropped pairs, saturating at 255.
- busyOUT  out  1  — high whenever the FSM is not in IDLE.

## Operation

- **Frame byte order:** SYNC_BYTE, L[15:8], L[7:0], R[15:8], R[7:0], CHK, where CHK = XOR of bytes 1–4.
- **FIFO write:** occurs on sampleValidIN when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- **FIFO full:** a pair arriving when full with no pop is dropped. overflowOUT is set, and dropCountOUT increments, saturating at 255.
- **FSM states:** IDLE, LOAD, WAIT_ACK, WAIT_READY. A 3-bit byte index (0–5) tracks position in the frame.
  - IDLE: when the FIFO is not empty and txReadyIN=1, pop the head into a 32-bit frame register, set index=0, go to LOAD.
  - LOAD: drive txDataOUT = byte[index] and txLoadOUT=1, go to WAIT_ACK.
  - WAIT_ACK: hold txLoadOUT=1 and txDataOUT stable until txReadyIN=0, then drive txLoadOUT=0 and go to WAIT_READY.
  - WAIT_READY: wait for txReadyIN=1. If index=5, go to IDLE; otherwise index+1 and go to LOAD.
- **Frame atomicity:** a frame, once popped, is always completed. New samples never alter the frame register.
- **Reset values (while nResetIN=0, and immediately on assertion mid-frame):** FSM=IDLE, index=0, FIFO empty, txLoadOUT=0, txDataOUT=8'h00, fifoCountOUT=0, overflowOUT=0, dropCountOUT=0, busyOUT=0. A partial frame is abandoned with no completion.
- overflowOUT and dropCountOUT clear only on reset.

## Timing

- **Pop latency:** a pop in cycle N (IDLE→LOAD) gives txLoadOUT=1 with byte 0 registered by cycle N+1.
- **Load deassertion:** txLoadOUT falls in the cycle after txReadyIN is first sampled low in WAIT_ACK.
- **Next byte:** txLoadOUT rises in the cycle after txReadyIN is sampled high in WAIT_READY, i.e. LOAD plus one register stage. Minimum 3 cycles per byte with an ideal UART.
- **Sample to txLoadOUT:** a push in cycle N into an empty FIFO, with txReadyIN=1, gives the pop at N+1 and txLoadOUT=1 at N+2.
- **Count update:** fifoCountOUT updates the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure

- **Shared package `dsp_uart_pkg`:**
  - FRAME_LEN=6
  - default SYNC_BYTE
  - FSM state encoding (2 bits)
  - the checksum function (XOR of 4 bytes)
- **Sub-module `sample_fifo`:** a 32-bit-wide synchronous FIFO with full/empty/count, first-word-fall-through head, and async active-low reset.
- **Framer top:** owns the FSM, the frame register, the byte mux, and the statistics counters.

## Test plan

- **Single frame:** push L=16'h1234, R=16'hABCD with the UART model acking after 10 cycles → bytes A5,12,34,AB,CD,40 in order. busyOUT falls after the 6th ack.
- **Back-pressure/overflow:** hold txReadyIN=0 and push 12 pairs (depth 8) → fifoCountOUT=8, dropCountOUT=4, overflowOUT=1. Release txReadyIN → 8 frames emitted in push order.
- **Saturation:** 300 drops → dropCountOUT=255, stable.
- **Full-and-pop same cycle:** FIFO full, push coincides with an IDLE pop → push accepted, dropCountOUT unchanged, count stays 8.
- **Handshake stability:** ack delayed 50 cycles → txDataOUT and txLoadOUT stable throughout WAIT_ACK. txLoadOUT falls exactly 1 cycle after txReadyIN goes low.
- **Reset mid-frame:** assert nResetIN after byte 2 → all outputs at reset values asynchronously. After release, the next push produces a fresh frame starting with A5.

Source files
------------

// File: rtl/dsp_uart_pkg.sv
// Shared definitions for the sample-to-UART framing path: frame geometry,
// default sync byte, framer state encoding and the frame checksum.
package dsp_uart_pkg;

   localparam int FRAME_LEN = 6;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD       = 2'd1,
      ST_WAIT_ACK   = 2'd2,
      ST_WAIT_READY = 2'd3
   } framer_state_t;

   function automatic logic [7:0] frameChecksum(input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3,
                                                input logic [7:0] b4);
      return b1 ^ b2 ^ b3 ^ b4;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a first-word-fall-through head. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   count_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  doPush, doPop;

   assign full_o  = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
      if (doPop)  rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
      case ({doPush, doPop})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/uart_sample_framer.sv
// Packs stereo sample pairs into 6-byte sync/checksum frames and feeds them
// one byte at a time to a UART transmitter through a load/ready handshake.
module uart_sample_framer
   import dsp_uart_pkg::*;
#(
   parameter int unsigned FIFO_ADDR_WIDTH = 3,
   parameter logic [7:0]  SYNC_BYTE       = DEFAULT_SYNC_BYTE
) (
   input  logic                     clockIN,
   input  logic                     nResetIN,
   input  logic [15:0]              sampleLeftIN,
   input  logic [15:0]              sampleRightIN,
   input  logic                     sampleValidIN,
   output logic [7:0]               txDataOUT,
   output logic                     txLoadOUT,
   input  logic                     txReadyIN,
   output logic [FIFO_ADDR_WIDTH:0] fifoCountOUT,
   output logic                     overflowOUT,
   output logic [7:0]               dropCountOUT,
   output logic                     busyOUT
);

   localparam logic [2:0] LAST_INDEX = 3'(FRAME_LEN - 1);

   framer_state_t state_q, state_d;
   logic [2:0]    index_q, index_d;
   logic [31:0]   frame_q, frame_d;
   logic [7:0]    txData_q, txData_d;
   logic          txLoad_q, txLoad_d;
   logic          busy_q, busy_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    dropCount_q, dropCount_d;

   logic [31:0]   fifoHead;
   logic          fifoFull, fifoEmpty, pop, drop;

   function automatic logic [7:0] frameByte(input logic [31:0] frame, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = frame[31:24];
         3'd2:    b = frame[23:16];
         3'd3:    b = frame[15:8];
         3'd4:    b = frame[7:0];
         3'd5:    b = frameChecksum(frame[31:24], frame[23:16], frame[15:8], frame[7:0]);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign pop  = (state_q == ST_IDLE) && !fifoEmpty && txReadyIN;
   assign drop = sampleValidIN && fifoFull && !pop;

   sample_fifo #(
      .ADDR_WIDTH(FIFO_ADDR_WIDTH),
      .DATA_WIDTH(32)
   ) u_fifo (
      .clk_i  (clockIN),
      .rst_ni (nResetIN),
      .push_i (sampleValidIN),
      .pop_i  (pop),
      .data_i ({sampleLeftIN, sampleRightIN}),
      .head_o (fifoHead),
      .full_o (fifoFull),
      .empty_o(fifoEmpty),
      .count_o(fifoCountOUT)
   );

   // Outputs are computed from the next state so they land in registers
   // together with the state they belong to.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      frame_d  = frame_q;
      txData_d = txData_q;
      txLoad_d = txLoad_q;
      case (state_q)
         ST_IDLE: begin
            txLoad_d = 1'b0;
            if (pop) begin
               frame_d  = fifoHead;
               index_d  = 3'd0;
               txData_d = frameByte(fifoHead, 3'd0);
               txLoad_d = 1'b1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            txLoad_d = 1'b1;
            state_d  = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (!txReadyIN) begin
               txLoad_d = 1'b0;
               state_d  = ST_WAIT_READY;
            end
         end
         ST_WAIT_READY: begin
            if (txReadyIN) begin
               if (index_q == LAST_INDEX) begin
                  state_d = ST_IDLE;
               end else begin
                  index_d  = index_q + 3'd1;
                  txData_d = frameByte(frame_q, index_q + 3'd1);
                  txLoad_d = 1'b1;
                  state_d  = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_comb begin
      overflow_d  = overflow_q | drop;
      dropCount_d = dropCount_q;
      if (drop && (dropCount_q != 8'hFF)) dropCount_d = dropCount_q + 8'd1;
   end

   always_ff @(posedge clockIN or negedge nResetIN) begin
      if (!nResetIN) begin
         state_q     <= ST_IDLE;
         index_q     <= 3'd0;
         frame_q     <= 32'h0;
         txData_q    <= 8'h00;
         txLoad_q    <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         dropCount_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         frame_q     <= frame_d;
         txData_q    <= txData_d;
         txLoad_q    <= txLoad_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign txDataOUT    = txData_q;
   assign txLoadOUT    = txLoad_q;
   assign busyOUT      = busy_q;
   assign overflowOUT  = overflow_q;
   assign dropCountOUT = dropCount_q;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Bench for uart_sample_framer: a UART ready/ack model feeds a byte scoreboard,
// a vector table covers frame contents, and hand sequences cover the corners.
module tb_uart_sample_framer;

   logic        clockIN;
   logic        nResetIN;
   logic [15:0] sampleLeftIN;
   logic [15:0] sampleRightIN;
   logic        sampleValidIN;
   logic [7:0]  txDataOUT;
   logic        txLoadOUT;
   logic        txReadyIN;
   logic [3:0]  fifoCountOUT;
   logic        overflowOUT;
   logic [7:0]  dropCountOUT;
   logic        busyOUT;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sbQ[$];

   int         ackDelay  = 1;
   int         busyLen   = 1;
   logic       holdReady = 1'b0;
   int         bytesDone = 0;
   int         phase     = 0;
   int         cnt       = 0;
   logic       fallPending = 1'b0;
   logic [7:0] curByte   = 8'h00;

   typedef struct {
      logic [15:0] left;
      logic [15:0] right;
      logic [47:0] frame;
   } vector_t;

   vector_t vectors[6];

   uart_sample_framer #(
      .FIFO_ADDR_WIDTH(3),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clockIN      (clockIN),
      .nResetIN     (nResetIN),
      .sampleLeftIN (sampleLeftIN),
      .sampleRightIN(sampleRightIN),
      .sampleValidIN(sampleValidIN),
      .txDataOUT    (txDataOUT),
      .txLoadOUT    (txLoadOUT),
      .txReadyIN    (txReadyIN),
      .fifoCountOUT (fifoCountOUT),
      .overflowOUT  (overflowOUT),
      .dropCountOUT (dropCountOUT),
      .busyOUT      (busyOUT)
   );

   initial begin
      clockIN = 1'b0;
      forever #5 clockIN = ~clockIN;
   end

   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
      @(negedge clockIN);
      sampleLeftIN  = l;
      sampleRightIN = r;
      sampleValidIN = 1'b1;
      @(negedge clockIN);
      sampleValidIN = 1'b0;
   endtask

   task automatic expectFrame(input logic [15:0] l, input logic [15:0] r);
      sbQ.push_back(8'hA5);
      sbQ.push_back(l[15:8]);
      sbQ.push_back(l[7:0]);
      sbQ.push_back(r[15:8]);
      sbQ.push_back(r[7:0]);
      sbQ.push_back(l[15:8] ^ l[7:0] ^ r[15:8] ^ r[7:0]);
   endtask

   task automatic waitBytes(input int target, input int budget);
      int n = 0;
      while (bytesDone < target && n < budget) begin
         @(posedge clockIN);
         n++;
      end
      checkOutput("bytesAcked", 32'(bytesDone), 32'(target));
   endtask

   // UART model: takes a byte when load is seen with ready high, keeps ready
   // high for ackDelay cycles, then low for busyLen cycles.
   initial begin
      txReadyIN = 1'b1;
      forever begin
         @(negedge clockIN);
         if (!nResetIN) begin
            phase     = 0;
            txReadyIN = 1'b1;
         end else if (holdReady) begin
            phase     = 0;
            txReadyIN = 1'b0;
         end else begin
            case (phase)
               0: begin
                  txReadyIN = 1'b1;
                  if (txLoadOUT) begin
                     if (sbQ.size() == 0) begin
                        checkOutput("unexpectedByte", 32'(txDataOUT), 32'hFFFF_FFFF);
                     end else begin
                        checkOutput("txByte", 32'(txDataOUT), 32'(sbQ.pop_front()));
                     end
                     curByte = txDataOUT;
                     cnt     = ackDelay;
                     phase   = 1;
                  end
               end
               1: begin
                  checkOutput("loadHeld", 32'(txLoadOUT), 32'd1);
                  checkOutput("dataHeld", 32'(txDataOUT), 32'(curByte));
                  cnt--;
                  if (cnt <= 0) begin
                     txReadyIN   = 1'b0;
                     cnt         = busyLen;
                     fallPending = 1'b1;
                     phase       = 2;
                  end
               end
               default: begin
                  if (fallPending) begin
                     checkOutput("loadFall", 32'(txLoadOUT), 32'd0);
                     fallPending = 1'b0;
                  end
                  cnt--;
                  if (cnt <= 0) begin
                     txReadyIN = 1'b1;
                     bytesDone++;
                     phase = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      int base;

      vectors[0] = '{16'h1234, 16'hABCD, 48'hA5_12_34_AB_CD_40};
      vectors[1] = '{16'h0000, 16'h0000, 48'hA5_00_00_00_00_00};
      vectors[2] = '{16'hFFFF, 16'hFFFF, 48'hA5_FF_FF_FF_FF_00};
      vectors[3] = '{16'h0102, 16'h0408, 48'hA5_01_02_04_08_0F};
      vectors[4] = '{16'hDEAD, 16'hBEEF, 48'hA5_DE_AD_BE_EF_22};
      vectors[5] = '{16'hA55A, 16'h0F0F, 48'hA5_A5_5A_0F_0F_FF};

      nResetIN      = 1'b0;
      sampleLeftIN  = 16'h0;
      sampleRightIN = 16'h0;
      sampleValidIN = 1'b0;

      repeat (3) @(negedge clockIN);
      checkOutput("rstTxLoad", 32'(txLoadOUT), 32'd0);
      checkOutput("rstTxData", 32'(txDataOUT), 32'h00);
      checkOutput("rstCount", 32'(fifoCountOUT), 32'd0);
      checkOutput("rstOverflow", 32'(overflowOUT), 32'd0);
      checkOutput("rstDrops", 32'(dropCountOUT), 32'd0);
      checkOutput("rstBusy", 32'(busyOUT), 32'd0);
      nResetIN = 1'b1;
      repeat (2) @(negedge clockIN);

      $display("[TB] frame vectors");
      for (int i = 0; i < 6; i++) begin
         ackDelay = (i == 0) ? 10 : 1;
         for (int b = 0; b < 6; b++) sbQ.push_back(vectors[i].frame[47 - 8*b -: 8]);
         base = bytesDone;
         applyStimulus(vectors[i].left, vectors[i].right);
         checkOutput("loadNotYet", 32'(txLoadOUT), 32'd0);
         checkOutput("countAfterPush", 32'(fifoCountOUT), 32'd1);
         @(negedge clockIN);
         checkOutput("loadLatency", 32'(txLoadOUT), 32'd1);
         checkOutput("firstByteSync", 32'(txDataOUT), 32'hA5);
         checkOutput("countAfterPop", 32'(fifoCountOUT), 32'd0);
         checkOutput("busyMidFrame", 32'(busyOUT), 32'd1);
         waitBytes(base + 6, 400);
         @(negedge clockIN);
         checkOutput("busyFall", 32'(busyOUT), 32'd0);
         checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
      end

      $display("[TB] slow acknowledge");
      ackDelay = 50;
      base = bytesDone;
      expectFrame(16'h5AA5, 16'h3C3C);
      applyStimulus(16'h5AA5, 16'h3C3C);
      waitBytes(base + 6, 1000);
      checkOutput("sbDrainedSlow", 32'(sbQ.size()), 32'd0);
      ackDelay = 1;

      $display("[TB] back-pressure and overflow");
      @(posedge clockIN);
      holdReady = 1'b1;
      base = bytesDone;
      for (int i = 0; i < 12; i++) begin
         if (i < 8) expectFrame(16'h1000 + 16'(i), 16'h2000 + 16'(i * 3));
         applyStimulus(16'h1000 + 16'(i), 16'h2000 + 16'(i * 3));
         if (i == 7) begin
            checkOutput("fullCount", 32'(fifoCountOUT), 32'd8);
            checkOutput("noOverflowYet", 32'(overflowOUT), 32'd0);
            checkOutput("noDropsYet", 32'(dropCountOUT), 32'd0);
         end
      end
      checkOutput("ovfCount", 32'(fifoCountOUT), 32'd8);
      checkOutput("ovfDrops", 32'(dropCountOUT), 32'd4);
      checkOutput("ovfFlag", 32'(overflowOUT), 32'd1);
      @(posedge clockIN);
      holdReady = 1'b0;
      waitBytes(base + 48, 2000);
      checkOutput("ovfDrained", 32'(fifoCountOUT), 32'd0);
      checkOutput("sbDrainedOvf", 32'(sbQ.size()), 32'd0);

      $display("[TB] push while full with simultaneous pop");
      @(posedge clockIN);
      holdReady = 1'b1;
      base = bytesDone;
      for (int i = 0; i < 8; i++) begin
         expectFrame(16'h3000 + 16'(i), 16'h4000 - 16'(i));
         applyStimulus(16'h3000 + 16'(i), 16'h4000 - 16'(i));
      end
      checkOutput("fpFull", 32'(fifoCountOUT), 32'd8);
      @(posedge clockIN);
      holdReady = 1'b0;
      @(negedge clockIN);
      expectFrame(16'h7777, 16'h8888);
      sampleLeftIN  = 16'h7777;
      sampleRightIN = 16'h8888;
      sampleValidIN = 1'b1;
      @(negedge clockIN);
      sampleValidIN = 1'b0;
      checkOutput("fpCount", 32'(fifoCountOUT), 32'd8);
      checkOutput("fpDrops", 32'(dropCountOUT), 32'd4);
      checkOutput("fpBusy", 32'(busyOUT), 32'd1);
      waitBytes(base + 54, 2500);
      checkOutput("sbDrainedFp", 32'(sbQ.size()), 32'd0);

      $display("[TB] drop counter saturation");
      @(posedge clockIN);
      holdReady = 1'b1;
      base = bytesDone;
      for (int i = 0; i < 8; i++) begin
         expectFrame(16'h5000 + 16'(i), 16'h6000 + 16'(i));
         applyStimulus(16'h5000 + 16'(i), 16'h6000 + 16'(i));
      end
      for (int i = 0; i < 300; i++) applyStimulus(16'hEEEE, 16'(i));
      checkOutput("satDrops", 32'(dropCountOUT), 32'd255);
      for (int i = 0; i < 5; i++) applyStimulus(16'hDDDD, 16'(i));
      checkOutput("satStable", 32'(dropCountOUT), 32'd255);
      checkOutput("satCount", 32'(fifoCountOUT), 32'd8);
      @(posedge clockIN);
      holdReady = 1'b0;
      waitBytes(base + 48, 2000);
      checkOutput("sbDrainedSat", 32'(sbQ.size()), 32'd0);

      $display("[TB] reset mid-frame");
      base = bytesDone;
      expectFrame(16'hCAFE, 16'hF00D);
      expectFrame(16'h1111, 16'h2222);
      applyStimulus(16'hCAFE, 16'hF00D);
      applyStimulus(16'h1111, 16'h2222);
      waitBytes(base + 2, 200);
      @(negedge clockIN);
      checkOutput("preRstBusy", 32'(busyOUT), 32'd1);
      checkOutput("preRstCount", 32'(fifoCountOUT), 32'd1);
      #1;
      nResetIN = 1'b0;
      sbQ.delete();
      #1;
      checkOutput("midRstTxLoad", 32'(txLoadOUT), 32'd0);
      checkOutput("midRstTxData", 32'(txDataOUT), 32'h00);
      checkOutput("midRstCount", 32'(fifoCountOUT), 32'd0);
      checkOutput("midRstOverflow", 32'(overflowOUT), 32'd0);
      checkOutput("midRstDrops", 32'(dropCountOUT), 32'd0);
      checkOutput("midRstBusy", 32'(busyOUT), 32'd0);
      repeat (2) @(negedge clockIN);
      nResetIN = 1'b1;
      repeat (2) @(negedge clockIN);
      base = bytesDone;
      expectFrame(16'h0BAD, 16'hBEEF);
      applyStimulus(16'h0BAD, 16'hBEEF);
      waitBytes(base + 6, 400);
      repeat (20) @(negedge clockIN);
      checkOutput("postRstBytes", 32'(bytesDone), 32'(base + 6));
      checkOutput("sbDrainedRst", 32'(sbQ.size()), 32'd0);
      checkOutput("postRstIdle", 32'(busyOUT), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
